// File: rtl/prbs31_checker_if.sv
// rtl/prbs31_checker_if.sv - serial receive bit stream into the PRBS31 checker
interface prbs31_checker_if;
  logic rx_bit;
  logic rx_valid;

  modport master (output rx_bit, output rx_valid);
  modport slave  (input rx_bit, input rx_valid);
endinterface

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 (x^31+x^28+1) checker with lock,
// windowed loss-of-lock detection and saturating error/bit counters
module prbs31_checker #(
  parameter int LOCK_MATCHES = 32,
  parameter int WINDOW       = 1024,
  parameter int LOL_THRESH   = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  prbs31_checker_if.slave       rx,
  input  logic                  clr_cnt,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  lol_sticky
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(LOL_THRESH + 1);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t          state, state_nx;
  logic [30:0]     h, h_nx;
  logic [4:0]      fill, fill_nx;
  logic [MW-1:0]   match_cnt, match_nx;
  logic [WW-1:0]   win_cnt, win_cnt_nx;
  logic [EW-1:0]   win_err, win_err_nx;
  logic [CNT_W-1:0] err_nx, bits_nx;
  logic            sticky_nx, pulse_nx;
  logic            pred, mismatch;

  assign pred     = h[30] ^ h[27];
  assign mismatch = rx.rx_bit ^ pred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    h_nx       = h;
    fill_nx    = fill;
    match_nx   = match_cnt;
    win_cnt_nx = win_cnt;
    win_err_nx = win_err;
    err_nx     = err_count;
    bits_nx    = bit_count;
    sticky_nx  = lol_sticky;
    pulse_nx   = 1'b0;

    if (rx.rx_valid) begin
      case (state)
        ST_SEARCH: begin
          h_nx = {h[29:0], rx.rx_bit};
          if (fill != 5'd31) begin
            fill_nx = fill + 5'd1;
          end else if (!mismatch && (h != '0)) begin
            // An all-zero history predicts zero forever; refusing it avoids locking on a dead line.
            if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
              state_nx   = ST_LOCKED;
              match_nx   = '0;
              win_cnt_nx = '0;
              win_err_nx = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else begin
            match_nx = '0;
          end
        end

        ST_LOCKED: begin
          h_nx = {h[29:0], pred};
          if (bit_count != '1) bits_nx = bit_count + 1'b1;
          if (mismatch) begin
            pulse_nx = 1'b1;
            if (err_count != '1) err_nx = err_count + 1'b1;
          end
          // The bit that completes a window starts the next one, so its error lands there.
          if (win_cnt == WW'(WINDOW - 1)) begin
            win_cnt_nx = '0;
            win_err_nx = EW'(mismatch);
          end else begin
            win_cnt_nx = win_cnt + 1'b1;
            win_err_nx = win_err + EW'(mismatch);
          end
          if (win_err_nx == EW'(LOL_THRESH)) begin
            state_nx  = ST_SEARCH;
            sticky_nx = 1'b1;
            fill_nx   = '0;
            match_nx  = '0;
          end
        end

        default: state_nx = ST_SEARCH;
      endcase
    end

    if (clr_cnt) begin
      err_nx    = '0;
      bits_nx   = '0;
      sticky_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h          <= '0;
      fill       <= '0;
      match_cnt  <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
      lol_sticky <= 1'b0;
    end else begin
      h          <= h_nx;
      fill       <= fill_nx;
      match_cnt  <= match_nx;
      win_cnt    <= win_cnt_nx;
      win_err    <= win_err_nx;
      locked     <= (state_nx == ST_LOCKED);
      err_pulse  <= pulse_nx;
      err_count  <= err_nx;
      bit_count  <= bits_nx;
      lol_sticky <= sticky_nx;
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - directed scoreboard bench for the PRBS31 checker
module tb_prbs31_checker;
  localparam int WINDOW = 1024;
  localparam int LOL    = 16;
  localparam int LOCKN  = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_cnt;
  logic        locked, err_pulse, lol_sticky;
  logic [15:0] err_count, bit_count;

  prbs31_checker_if rx();

  prbs31_checker dut (
    .clk(clk), .rst(rst), .rx(rx), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .bit_count(bit_count), .lol_sticky(lol_sticky)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [30:0] g;
  logic m_locked, m_sticky;
  int   m_err, m_bits, search_bits, locked_bits, werr;

  typedef struct {
    logic        locked;
    logic        pulse;
    logic        sticky;
    logic [15:0] errc;
    logic [15:0] bitc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic gen_bit();
    logic o;
    o = g[30] ^ g[27];
    g = {g[29:0], o};
    return o;
  endfunction

  task automatic model_clear();
    g = 31'h7FFF_FFFF;
    m_locked = 0; m_sticky = 0;
    m_err = 0; m_bits = 0; search_bits = 0; locked_bits = 0; werr = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; drives one cycle and checks the result at the next negedge.
  task automatic step(input logic b, input logic v, input logic clr, input logic clean);
    exp_t e;
    logic pulse;
    pulse = 1'b0;
    rx.rx_bit = b; rx.rx_valid = v; clr_cnt = clr;
    if (v) begin
      if (m_locked) begin
        locked_bits++;
        if (locked_bits % WINDOW == 0) werr = 0;
        if (m_bits < 65535) m_bits++;
        if (!clean) begin
          pulse = 1'b1;
          if (m_err < 65535) m_err++;
          werr++;
        end
        if (werr == LOL) begin
          m_locked = 0; m_sticky = 1; search_bits = 0;
        end
      end else begin
        search_bits = clean ? search_bits + 1 : 0;
        if (search_bits == LOCKN) begin
          m_locked = 1; locked_bits = 0; werr = 0;
        end
      end
    end
    if (clr) begin
      m_err = 0; m_bits = 0; m_sticky = 0;
    end
    e.locked = m_locked; e.pulse = pulse; e.sticky = m_sticky;
    e.errc = 16'(m_err); e.bitc = 16'(m_bits);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("locked", {15'd0, locked}, {15'd0, e.locked});
    chk("err_pulse", {15'd0, err_pulse}, {15'd0, e.pulse});
    chk("lol_sticky", {15'd0, lol_sticky}, {15'd0, e.sticky});
    chk("err_count", err_count, e.errc);
    chk("bit_count", bit_count, e.bitc);
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = gen_bit();
      step(b, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic bad(input logic clr);
    logic b;
    b = gen_bit();
    step(~b, 1'b1, clr, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx.rx_valid = 1'b0; rx.rx_bit = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_locked", {15'd0, locked}, 16'd0);
    chk("rst_err_pulse", {15'd0, err_pulse}, 16'd0);
    chk("rst_sticky", {15'd0, lol_sticky}, 16'd0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_bit_count", bit_count, 16'd0);
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    int nvalid;
    model_clear();
    do_reset();

    // Clean stream: lock after 63 valid bits, then 1000 checked bits
    good(62);
    chk("not_locked_at_62", {15'd0, locked}, 16'd0);
    good(1);
    chk("locked_at_63", {15'd0, locked}, 16'd1);
    good(1000);
    chk("bits_1000", bit_count, 16'd1000);
    chk("errs_0", err_count, 16'd0);

    // Single inverted bit counts once
    bad(1'b0);
    good(100);
    chk("single_err_count", err_count, 16'd1);
    chk("single_err_locked", {15'd0, locked}, 16'd1);

    // 16 errors in one window force loss of lock, then relock after 63 bits
    step(gen_bit(), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < LOL; i++) begin
      bad(1'b0);
      if (i != LOL - 1) good(4);
    end
    chk("lol_dropped", {15'd0, locked}, 16'd0);
    chk("lol_sticky_set", {15'd0, lol_sticky}, 16'd1);
    chk("lol_err_count", err_count, 16'd16);
    good(62);
    chk("relock_not_yet", {15'd0, locked}, 16'd0);
    good(1);
    chk("relock", {15'd0, locked}, 16'd1);

    // Window boundary: error on bit 1024 opens the next window
    for (int i = 0; i < 1200 && m_locked; i++) begin
      int k;
      logic inj, b;
      k = locked_bits + 1;
      inj = (k >= 1009 && k <= 1024) || (k >= 1030 && k <= 1043) || (k == 1050);
      b = gen_bit();
      step(inj ? ~b : b, 1'b1, 1'b0, !inj);
      if (k == 1049) chk("window_split_no_lol", {15'd0, locked}, 16'd1);
    end
    chk("window_lol", {15'd0, locked}, 16'd0);
    good(LOCKN);

    // clr_cnt coincident with an error: pulse still fires, counter reads zero
    bad(1'b1);
    chk("clr_err_pulse", {15'd0, err_pulse}, 16'd1);
    chk("clr_err_count", err_count, 16'd0);
    chk("clr_sticky", {15'd0, lol_sticky}, 16'd0);
    good(20);

    // Bubbled stream from reset: latency and counts in valid bits only
    do_reset();
    nvalid = 0;
    while (nvalid < 400) begin
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(1, 4);
        for (int j = 0; j < gap; j++) step(1'($urandom), 1'b0, 1'b0, 1'b1);
      end
      good(1);
      nvalid++;
    end
    chk("bubble_bit_count", bit_count, 16'(400 - LOCKN));
    chk("bubble_err_count", err_count, 16'd0);

    // All-zero input never locks
    do_reset();
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_locked", {15'd0, locked}, 16'd0);
    chk("zero_bits", bit_count, 16'd0);
    chk("zero_errs", err_count, 16'd0);

    // Asynchronous reset mid-stream
    do_reset();
    good(LOCKN + 50);
    bad(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_locked", {15'd0, locked}, 16'd0);
    chk("async_err_pulse", {15'd0, err_pulse}, 16'd0);
    chk("async_sticky", {15'd0, lol_sticky}, 16'd0);
    chk("async_err_count", err_count, 16'd0);
    chk("async_bit_count", bit_count, 16'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
